// File: rtl/uart_tx_mmio_if.sv
// Core data-bus view of the UART transmitter register window.
interface uart_tx_mmio_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_w_enable;
    logic        mem_r_enable;
    logic [31:0] mmio_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_w_enable,
        output mem_r_enable,
        input  mmio_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_w_enable,
        input  mem_r_enable,
        output mmio_rdata
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA store pushes a byte into a FIFO,
// STATUS load reports FIFO/line state, 8N1 frames are shifted out LSB first.
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave bus,
    output logic          txd,
    output logic          tx_busy
);
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam logic [31:0] ADDR_TXDATA = BASE_ADDR;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd4;
    localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [15:0]      baud_cnt, baud_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             txd_nxt;
    logic             baud_done;
    logic             pop;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             fifo_full, fifo_empty, push;
    logic [31:0]      status_word;

    assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty  = (count == '0);
    assign push        = bus.mem_w_enable && (bus.mem_addr == ADDR_TXDATA) && !fifo_full;
    assign baud_done   = (baud_cnt == BAUD_LAST);
    assign status_word = {20'b0, 8'(count), 1'b0, tx_busy, fifo_empty, fifo_full};

    // Occupancy after this edge; a push while full was already blocked above.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO pointers and count; reset empties the queue and drops coincident strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !reset) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
    end

    // Frame sequencer next-state: IDLE pops, START/DATA/STOP each last CLKS_PER_BIT cycles.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        txd_nxt   = txd;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                txd_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    txd_nxt   = 1'b0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    txd_nxt   = shift[0];
                    state_nxt = ST_DATA;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        txd_nxt   = 1'b1;
                        state_nxt = ST_STOP;
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        shift_nxt = {1'b0, shift[7:1]};
                        txd_nxt   = shift[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

    // Sequencer state register; txd and tx_busy are registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            txd      <= txd_nxt;
            tx_busy  <= (state_nxt != ST_IDLE) || (count_nxt != '0);
        end
    end

    // Read data is only non-zero the cycle after a STATUS load.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mmio_rdata <= '0;
        end else if (bus.mem_r_enable && (bus.mem_addr == ADDR_STATUS)) begin
            bus.mmio_rdata <= status_word;
        end else begin
            bus.mmio_rdata <= '0;
        end
    end
endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, 2..64.
REQ-003 Parameter BASE_ADDR, default 32'h1000_0000, byte address of the register window.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_addr  input  32  core data-bus byte address.
REQ-007 mem_wdata  input  32  core write data.
REQ-008 mem_w_enable  input  1  core store strobe, one cycle per store.
REQ-009 mem_r_enable  input  1  core load strobe, one cycle per load.
REQ-010 mmio_rdata  output  32  registered read data for this window.
REQ-011 txd  output  1  UART serial line; idle high.
REQ-012 tx_busy  output  1  high while the FIFO is non-empty or a frame is in progress.

Function
REQ-013 Address decode: TXDATA = BASE_ADDR+0; STATUS = BASE_ADDR+4; compare the full 32 bits; other addresses are ignored.
REQ-014 Store to TXDATA: push mem_wdata[7:0] into the FIFO in the same edge; bits [31:8] ignored.
REQ-015 Store to TXDATA while the FIFO is full: data dropped, FIFO and pointers unchanged, no error flag.
REQ-016 Full is sampled before the edge: a push while full is dropped even if a pop occurs on the same edge.
REQ-017 Push and pop on the same edge while not full and not empty: both take effect; count unchanged.
REQ-018 FIFO pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1 bits; count ranges 0..FIFO_DEPTH.
REQ-019 Load from STATUS: mmio_rdata = {20'b0, count[7:0] in bits[11:4], tx_busy in bit 2, fifo_empty in bit 1, fifo_full in bit 0}, with count zero-extended; valid the cycle after mem_r_enable.
REQ-020 Load from TXDATA or an undecoded address: mmio_rdata = 0 on the following cycle.
REQ-021 mmio_rdata is 0 in any cycle not following a decoded load.
REQ-022 FSM states: IDLE, START, DATA, STOP; 16-bit baud counter; 3-bit bit index; 8-bit shift register.
REQ-023 IDLE with FIFO non-empty: pop the head into the shift register, zero the counter, go to START; txd=0 from the next cycle.
REQ-024 START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-025 DATA: txd=shift[0], LSB first, for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 7 go to STOP.
REQ-026 STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-027 Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the txd falling edge to the end of the stop bit.
REQ-028 A non-empty FIFO at the end of STOP: the FSM re-enters IDLE for exactly one cycle, then START; the inter-frame gap is 1 extra idle-high cycle.
REQ-029 The baud counter counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit change.
REQ-030 txd is driven from a register; it carries no combinational path from the bus inputs.
REQ-031 Store to TXDATA into an empty FIFO while the FSM is IDLE: push at edge t, pop at edge t+1, txd low from cycle t+2.

Reset
REQ-032 While reset=1 at an edge: FSM to IDLE, FIFO pointers and count to 0, counter and index to 0, txd=1, mmio_rdata=0; tx_busy is then 0.
REQ-033 Reset asserted mid-frame aborts the frame: txd=1 from the next cycle and FIFO contents are discarded.
REQ-034 Bus strobes coincident with reset are ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-035 Store 0x55 to TXDATA from idle -> txd low at t+2, then bits 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; total 40 cycles; tx_busy returns to 0.
REQ-036 10 back-to-back stores 0x00..0x09 -> 0x00 is transmitted, 0x01..0x08 are queued, 0x09 is dropped as full at push 10; bytes 0x00..0x08 are sent in order, each frame separated by exactly 1 idle cycle.
REQ-037 Load STATUS after reset -> next-cycle mmio_rdata = 0x0000_0002.
REQ-038 Load STATUS with 8 queued bytes and TX active -> mmio_rdata = 0x0000_0085.
REQ-039 Reset asserted on cycle 15 of a 0xA5 frame -> txd=1 next cycle, STATUS reads 0x0000_0002, and no further frame is sent.
REQ-040 Store to BASE_ADDR+8 and a load from TXDATA -> no FIFO change; the load returns 0.
